// File: rtl/drain_pkg.sv
// Shared sizes and FSM encoding for the output-buffer drain path.
package drain_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/result_drain_if.sv
// Valid/ready result stream from the drain toward the host.
interface result_drain_if;
  logic                        m_valid;
  logic [drain_pkg::DATA_W-1:0] m_data;
  logic                        m_last;
  logic                        m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/drain_fifo2.sv
// Two-entry skid FIFO; a push and a pop in the same cycle are allowed even when full.
module drain_fifo2
  import drain_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              valid_o,
  output logic [1:0]        occ_o
);
  logic [DATA_W-1:0] mem_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        occ_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage is only two words and its head is visible on m_data, so it is reset too.
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;
endmodule

// File: rtl/result_drain.sv
// Sweeps the output buffer after ap_done and streams each word to the host,
// absorbing the 1-cycle memory latency and host backpressure with a 2-word FIFO.
module result_drain
  import drain_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_done,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addrO,
  input  logic [DATA_W-1:0] dataO,
  result_drain_if.master    m,
  output logic              busy,
  output logic              drain_done,
  output logic              overrun
);
  localparam logic [ADDR_W:0]   DEPTH_N  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W:0]   n_q, rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q, drain_done_q, overrun_q;

  logic [ADDR_W:0]   n_d;
  logic              fifo_valid, pop, issue, head_last;
  logic [1:0]        occ;
  logic [2:0]        load, limit;

  drain_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (dataO),
    .pop_i       (pop),
    .head_o      (m.m_data),
    .valid_o     (fifo_valid),
    .occ_o       (occ)
  );

  assign n_d   = (len > DEPTH_N) ? DEPTH_N : len;
  assign pop   = fifo_valid & m.m_ready;
  // Issue only if the word still fits after this cycle's pop, counting the read already in flight.
  assign load  = {1'b0, occ} + {2'b0, inflight_q};
  assign limit = 3'd2 + {2'b0, pop};
  assign issue = (state_q == DRAIN) && (load < limit);

  assign head_last = (wr_q == n_q - CNT_ONE);
  assign m.m_valid = fifo_valid;
  assign m.m_last  = fifo_valid & head_last;

  assign addrO      = addr_q;
  assign busy       = (state_q != IDLE);
  assign drain_done = drain_done_q;
  assign overrun    = overrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates, so every arm below sees the pre-edge counter values.
      drain_done_q <= 1'b0;
      inflight_q   <= issue;
      case (state_q)
        IDLE: begin
          if (ap_done) begin
            n_q <= n_d;
            if (n_d == '0) begin
              drain_done_q <= 1'b1;
            end else begin
              rd_q    <= '0;
              wr_q    <= '0;
              addr_q  <= '0;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (ap_done) overrun_q <= 1'b1;
          if (pop) wr_q <= wr_q + CNT_ONE;
          if (issue) begin
            rd_q <= rd_q + CNT_ONE;
            if (rd_q + CNT_ONE == n_q) state_q <= FLUSH;
            else                       addr_q  <= addr_q + ADDR_ONE;
          end
        end
        FLUSH: begin
          if (ap_done) overrun_q <= 1'b1;
          if (pop) begin
            wr_q <= wr_q + CNT_ONE;
            if (head_last) begin
              state_q      <= IDLE;
              drain_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/result_drain.md
# result_drain

Host-side reader for the systolic array's output buffer. After the core pulses `ap_done`, it sweeps `addrO` over the result words and forwards each `dataO` word onto a valid/ready stream toward the host, absorbing the output memory's 1-cycle read latency and any host backpressure. It sits beside `top`, on the opposite side of the `addrO`/`dataO` port from the core, and is the read-back counterpart of the host write path that loads memA, memB and instruction memory.

## Interface
- `DATA_W`, 32, result word width (matches `dataO`)
- `ADDR_W`, 7, output-buffer address width (matches `addrO`)
- `DEPTH`, 128, number of words in the output buffer
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset); release is sampled on `clk`
- `ap_done`  in  1  core completion pulse; starts a drain
- `len`  in  `ADDR_W`+1  number of words to drain; sampled in the cycle `ap_done`=1
- `addrO`  out  `ADDR_W`  read address to the output buffer
- `dataO`  in  `DATA_W`  read data; valid one cycle after `addrO` is presented
- `m_valid`  out  1  stream word valid
- `m_data`  out  `DATA_W`  stream word
- `m_last`  out  1  marks the final word of a drain
- `m_ready`  in  1  host accepts the word when `m_valid`=1 and `m_ready`=1
- `busy`  out  1  drain in progress
- `drain_done`  out  1  single-cycle pulse when a drain completes
- `overrun`  out  1  sticky; set if `ap_done` arrives while `busy`=1

## Operation
- States: IDLE, DRAIN, FLUSH.
- IDLE: on `ap_done`=1, latch `min(len, DEPTH)` as `n`.
  - If `n`=0, pulse `drain_done` next cycle and stay in IDLE.
  - Otherwise clear the read counter `rd` and the word counter `wr`, then go to DRAIN.
- DRAIN: `addrO`=`rd`.
  - A read issues in a cycle when `occupancy + inflight - pop < 2`. `pop` is the handshake in that cycle; `inflight` is a 1-bit flag for the read issued last cycle.
  - On issue, `rd` increments.
  - When `rd` reaches `n`, go to FLUSH.
- The returned `dataO` word is written into a 2-entry FIFO in the cycle after its issue. The FIFO head drives `m_data`/`m_valid`.
- `m_last`=1 when the head word is word index `n`-1.
- FLUSH: continue until the handshake of the last word, then return to IDLE and pulse `drain_done` in the following cycle.
- `ap_done` while `busy`=1 is ignored (no restart, latched `n` unchanged) and sets `overrun`. `overrun` clears only on reset.
- `busy`=1 in DRAIN and FLUSH.
- `addrO` holds its last value when no read is issued. Reads never go past `n`-1; nothing wraps.

## Timing
- Reset values:
  - `m_valid`=0, `m_last`=0, `m_data`=0
  - `addrO`=0, `busy`=0, `drain_done`=0, `overrun`=0
  - FIFO empty, state IDLE
- Reset asserted mid-drain aborts immediately. No further reads; the partial stream is dropped.
- With `ap_done` in cycle 0 and `m_ready` held high:
  - `addrO`=0 in cycle 1, `dataO` word 0 in cycle 2.
  - `m_valid` with word 0 in cycle 3, then one word per cycle.
  - Last word in cycle 2+`n`; `drain_done` in cycle 3+`n`.
- With `m_ready`=0: `m_valid`/`m_data`/`m_last` hold stable. At most 2 words are buffered, with no read in flight beyond capacity. No word is lost or duplicated.
- `m_valid` never deasserts without a handshake.

## Structure
- Package `drain_pkg`: `DATA_W`, `ADDR_W`, `DEPTH` defaults and the state enum (IDLE/DRAIN/FLUSH).
- One sub-module, `drain_fifo2`: 2-entry FIFO with push/pop, occupancy, and simultaneous push+pop when full (pop first).
- The FSM, counters and credit logic live in `result_drain`.

## Test plan
- Reset, then `ap_done` with `len`=4, buffer word k = k+1, `m_ready`=1 → words 1,2,3,4 in cycles 3–6; `m_last` only in cycle 6; `drain_done` in cycle 7.
- `len`=8, `m_ready` toggling 1,0,0,1 repeating → exactly 8 words in order 1..8; data stable while stalled; addresses never exceed 7.
- `len`=0 → no `addrO` activity, no `m_valid`; `drain_done` in cycle 1.
- `len`=200 → exactly 128 words (addresses 0..127); `m_last` on word 127.
- Second `ap_done` during a `len`=16 drain → drain completes 16 words unchanged; `overrun`=1 until reset.
- `rst`=0 after 5 words of a `len`=16 drain → all outputs at reset values immediately. A new `ap_done` with `len`=2 after release → words 0,1 only.
